// File: rtl/idc_job_scheduler.sv
// idc_job_scheduler: round-robin job capture for two requesters, a 64-entry
// pixel buffer, a contiguous 64-beat burst to the IDC core, and return of
// the 16 result pixels tagged with the owning requester.
module idc_job_scheduler #(
    parameter int TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    input  logic       s0_valid,
    input  logic [6:0] s0_data,
    input  logic [3:0] s0_op,
    input  logic       s1_valid,
    input  logic [6:0] s1_data,
    input  logic [3:0] s1_op,
    output logic       core_in_valid,
    output logic [6:0] core_in_data,
    output logic [3:0] core_op,
    input  logic       core_out_valid,
    input  logic [6:0] core_out_data,
    output logic       res_valid,
    output logic [6:0] res_data,
    output logic       res_id,
    output logic       err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {C_IDLE, C_FILL, C_FULL} cap_st_t;
    typedef enum logic [1:0] {K_IDLE, K_BURST, K_WAIT, K_DRAIN} core_st_t;

    typedef struct packed {
        logic       vld;
        logic [6:0] data;
        logic [3:0] op;
    } core_beat_t;

    typedef struct packed {
        logic       vld;
        logic [6:0] data;
        logic       id;
    } res_beat_t;

    cap_st_t    c_st, c_nxt;
    core_st_t   k_st, k_nxt;
    logic [1:0] grant_d;
    logic       cap_id, cap_id_d;
    logic       core_id, core_id_d;
    logic       rr_pri, rr_d;     // requester that wins the next tie
    logic       win;
    logic [5:0] ccnt, ccnt_d;
    logic [5:0] bcnt, bcnt_d;
    logic [TW-1:0] tmr, tmr_d;
    logic [3:0] rcnt, rcnt_d;
    logic       err_d, busy_d;
    logic       acc, buf_free;
    logic [6:0] beat_pix;
    logic [3:0] beat_op;
    core_beat_t cb_q, cb_d;
    res_beat_t  rb_q, rb_d;

    logic [6:0] pix_buf [0:63];
    logic [3:0] op_buf  [0:14];

    assign acc      = (grant[0] & s0_valid) | (grant[1] & s1_valid);
    assign beat_pix = cap_id ? s1_data : s0_data;
    assign beat_op  = cap_id ? s1_op   : s0_op;

    assign core_in_valid = cb_q.vld;
    assign core_in_data  = cb_q.data;
    assign core_op       = cb_q.op;
    assign res_valid     = rb_q.vld;
    assign res_data      = rb_q.data;
    assign res_id        = rb_q.id;

    // Job buffer write; contents need no reset since the capture count gates use.
    always_ff @(posedge clk) begin
        if (c_st == C_FILL && acc) begin
            pix_buf[ccnt] <= beat_pix;
            if (ccnt < 6'd15)
                op_buf[ccnt[3:0]] <= beat_op;
        end
    end

    // Capture FSM next state: arbitrate, fill the buffer, hold until the burst frees it.
    always_comb begin
        c_nxt    = c_st;
        grant_d  = grant;
        cap_id_d = cap_id;
        rr_d     = rr_pri;
        ccnt_d   = ccnt;
        win      = 1'b0;
        case (c_st)
            C_IDLE: begin
                if (|req) begin
                    win      = (&req) ? rr_pri : req[1];
                    grant_d  = win ? 2'b10 : 2'b01;
                    cap_id_d = win;
                    rr_d     = ~win;
                    c_nxt    = C_FILL;
                end
            end
            C_FILL: begin
                if (acc) begin
                    ccnt_d = ccnt + 6'd1;
                    if (ccnt == 6'd63) begin
                        c_nxt   = C_FULL;
                        grant_d = 2'b00;
                    end
                end
            end
            C_FULL: begin
                if (buf_free)
                    c_nxt = C_IDLE;
            end
            default: c_nxt = C_IDLE;
        endcase
    end

    // Core FSM next state and the next values of all registered core/result outputs.
    // The output register is loaded one cycle ahead, so the first burst beat is
    // presented in the cycle the FSM enters K_BURST.
    always_comb begin
        k_nxt     = k_st;
        core_id_d = core_id;
        bcnt_d    = bcnt;
        tmr_d     = tmr;
        rcnt_d    = rcnt;
        cb_d      = '0;
        rb_d      = '0;
        err_d     = 1'b0;
        buf_free  = 1'b0;
        case (k_st)
            K_IDLE: begin
                if (c_st == C_FULL) begin
                    core_id_d = cap_id;
                    bcnt_d    = 6'd0;
                    cb_d.vld  = 1'b1;
                    cb_d.data = pix_buf[0];
                    cb_d.op   = op_buf[0];
                    k_nxt     = K_BURST;
                end
            end
            K_BURST: begin
                if (bcnt == 6'd63) begin
                    buf_free = 1'b1;
                    tmr_d    = '0;
                    k_nxt    = K_WAIT;
                end else begin
                    bcnt_d    = bcnt + 6'd1;
                    cb_d.vld  = 1'b1;
                    cb_d.data = pix_buf[bcnt_d];
                    cb_d.op   = (bcnt_d < 6'd15) ? op_buf[bcnt_d[3:0]] : 4'd0;
                end
            end
            K_WAIT: begin
                tmr_d = tmr + 1'b1;
                if (core_out_valid) begin
                    rb_d.vld  = 1'b1;
                    rb_d.data = core_out_data;
                    rb_d.id   = core_id;
                    rcnt_d    = 4'd1;
                    k_nxt     = K_DRAIN;
                end else if (tmr == TW'(TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    k_nxt = K_IDLE;
                end
            end
            K_DRAIN: begin
                if (core_out_valid) begin
                    rb_d.vld  = 1'b1;
                    rb_d.data = core_out_data;
                    rb_d.id   = core_id;
                    rcnt_d    = rcnt + 4'd1;
                    if (rcnt == 4'd15)
                        k_nxt = K_IDLE;
                end
            end
            default: k_nxt = K_IDLE;
        endcase
        busy_d = (c_nxt != C_IDLE) || (k_nxt != K_IDLE);
    end

    // State and output registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_st    <= C_IDLE;
            k_st    <= K_IDLE;
            grant   <= 2'b00;
            cap_id  <= 1'b0;
            core_id <= 1'b0;
            rr_pri  <= 1'b0;
            ccnt    <= '0;
            bcnt    <= '0;
            tmr     <= '0;
            rcnt    <= '0;
            cb_q    <= '0;
            rb_q    <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            c_st    <= c_nxt;
            k_st    <= k_nxt;
            grant   <= grant_d;
            cap_id  <= cap_id_d;
            core_id <= core_id_d;
            rr_pri  <= rr_d;
            ccnt    <= ccnt_d;
            bcnt    <= bcnt_d;
            tmr     <= tmr_d;
            rcnt    <= rcnt_d;
            cb_q    <= cb_d;
            rb_q    <= rb_d;
            err     <= err_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_idc_job_scheduler.sv
// Directed bench for idc_job_scheduler: timing vector table for a single job,
// plus sequences for reset abort, gapped capture, round-robin, timeout and drain gaps.
module tb_idc_job_scheduler;

    logic       clk, rst;
    logic [1:0] req, grant;
    logic       s0_valid, s1_valid;
    logic [6:0] s0_data, s1_data;
    logic [3:0] s0_op, s1_op;
    logic       core_in_valid, core_out_valid;
    logic [6:0] core_in_data, core_out_data;
    logic [3:0] core_op;
    logic       res_valid, res_id, err, busy;
    logic [6:0] res_data;

    idc_job_scheduler #(.TIMEOUT(256)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_op(s0_op),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_op(s1_op),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data), .core_op(core_op),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .err(err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Requester job contents: requester 0 sends 0..63 with op 5, requester 1
    // sends 63..0 with op = beat index. Ops past beat 14 are junk on purpose.
    function automatic logic [6:0] pat(input int r, input int k);
        return (r != 0) ? 7'(63 - k) : 7'(k);
    endfunction
    function automatic logic [3:0] opv(input int r, input int k);
        return (r != 0) ? 4'(k) : 4'd5;
    endfunction

    // Requester feeder: offers a beat whenever granted, optionally every other cycle.
    logic gap0 = 1'b0, gap1 = 1'b0;
    int   fc0, fc1;
    logic ph0, ph1, a0, a1;
    initial begin
        s0_valid = 0; s0_data = 0; s0_op = 0;
        s1_valid = 0; s1_data = 0; s1_op = 0;
        fc0 = 0; fc1 = 0; ph0 = 0; ph1 = 0;
        forever begin
            @(negedge clk);
            a0 = grant[0] & s0_valid;
            a1 = grant[1] & s1_valid;
            @(posedge clk); #1;
            if (a0) fc0++;
            if (a1) fc1++;
            if (rst || !grant[0]) fc0 = 0;
            if (rst || !grant[1]) fc1 = 0;
            ph0 = ~ph0;
            ph1 = ~ph1;
            s0_valid = grant[0] && (!gap0 || ph0);
            s1_valid = grant[1] && (!gap1 || ph1);
            s0_data = pat(0, fc0); s0_op = opv(0, fc0);
            s1_data = pat(1, fc1); s1_op = opv(1, fc1);
        end
    end

    // Model IDC core: collects a 64-beat burst, then returns every 4th pixel.
    logic       model_en = 1'b1;
    int         model_lat = 3;
    int         model_gap = 0;
    logic [6:0] mb [64];
    int         mn;
    initial begin
        core_out_valid = 0;
        core_out_data  = 0;
        forever begin
            mn = 0;
            while (mn < 64) begin
                @(negedge clk);
                if (rst) mn = 0;
                else if (core_in_valid) begin
                    mb[mn] = core_in_data;
                    mn++;
                end
            end
            if (model_en) begin
                repeat (model_lat) @(posedge clk);
                for (int j = 0; j < 16; j++) begin
                    @(posedge clk); #1;
                    core_out_valid = 1'b1;
                    core_out_data  = mb[4*j];
                    repeat (model_gap) begin
                        @(posedge clk); #1;
                        core_out_valid = 1'b0;
                        core_out_data  = 0;
                    end
                end
                @(posedge clk); #1;
                core_out_valid = 1'b0;
                core_out_data  = 0;
            end
        end
    end

    // Output monitors.
    logic [7:0]  rq[$];
    logic [10:0] ciq[$];
    int civq[$], fallq[$], runq[$], errq[$], gcq[$];
    logic [1:0] gq[$];
    logic civ_p = 1'b0;
    logic [1:0] g_p = 2'b00;
    int run = 0;
    always @(negedge clk) begin
        if (res_valid) rq.push_back({res_id, res_data});
        if (core_in_valid) ciq.push_back({core_op, core_in_data});
        if (core_in_valid && !civ_p) civq.push_back(cyc);
        if (!core_in_valid && civ_p) begin
            fallq.push_back(cyc);
            runq.push_back(run);
        end
        run = core_in_valid ? run + 1 : 0;
        if (err) errq.push_back(cyc);
        if (grant != 2'b00 && g_p == 2'b00) begin
            gq.push_back(grant);
            gcq.push_back(cyc);
        end
        civ_p = core_in_valid;
        g_p   = grant;
    end

    typedef struct {
        int         cyc;
        logic [1:0] g;
        logic       civ;
        logic [6:0] cd;
        logic [3:0] cop;
        logic       busy;
    } vec_t;

    function automatic vec_t mkv(input int c, input logic [1:0] g, input logic v,
                                 input logic [6:0] d, input logic [3:0] o, input logic b);
        vec_t x;
        x.cyc = c; x.g = g; x.civ = v; x.cd = d; x.cop = o; x.busy = b;
        return x;
    endfunction

    task automatic run_job(input int r);
        int k = 0;
        req[r] = 1'b1;
        while (!grant[r] && k < 300) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("grant req%0d", r), int'(grant[r]), 1);
        req[r] = 1'b0;
    endtask

    task automatic wait_res(input int n, input int budget);
        int k = 0;
        while (rq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("result beat count", rq.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("return to idle", int'(busy), 0);
    endtask

    task automatic check_res(input int base, input int r);
        logic [7:0] got;
        for (int j = 0; j < 16; j++) begin
            got = (rq.size() > base + j) ? rq[base + j] : 8'hFF;
            check($sformatf("res[%0d] data", base + j), int'(got[6:0]), int'(pat(r, 4*j)));
            check($sformatf("res[%0d] id", base + j), int'(got[7]), r);
        end
    endtask

    vec_t vt[10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vt[0] = mkv(0,   2'b00, 0, 0,  0, 0);
        vt[1] = mkv(1,   2'b01, 0, 0,  0, 1);
        vt[2] = mkv(64,  2'b01, 0, 0,  0, 1);
        vt[3] = mkv(65,  2'b00, 0, 0,  0, 1);
        vt[4] = mkv(66,  2'b00, 1, 0,  5, 1);
        vt[5] = mkv(67,  2'b00, 1, 1,  5, 1);
        vt[6] = mkv(80,  2'b00, 1, 14, 5, 1);
        vt[7] = mkv(81,  2'b00, 1, 15, 0, 1);
        vt[8] = mkv(129, 2'b00, 1, 63, 0, 1);
        vt[9] = mkv(130, 2'b00, 0, 0,  0, 1);

        rst = 1'b1;
        req = 2'b00;
        repeat (2) @(negedge clk);
        check("rst grant", int'(grant), 0);
        check("rst core_in_valid", int'(core_in_valid), 0);
        check("rst core_in_data", int'(core_in_data), 0);
        check("rst core_op", int'(core_op), 0);
        check("rst res_valid", int'(res_valid), 0);
        check("rst res_data", int'(res_data), 0);
        check("rst res_id", int'(res_id), 0);
        check("rst err", int'(err), 0);
        check("rst busy", int'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Reset in the middle of a burst clears outputs without waiting for a clock.
        run_job(0);
        k = 0;
        while (!core_in_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("burst started", int'(core_in_valid), 1);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst core_in_valid", int'(core_in_valid), 0);
        check("async rst core_in_data", int'(core_in_data), 0);
        check("async rst busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single job from requester 0, cycle-exact vector table.
        @(posedge clk); #1 req = 2'b01;
        for (int c = 0; c <= 130; c++) begin
            @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                if (vt[i].cyc == c) begin
                    check($sformatf("vec%0d grant", i), int'(grant), int'(vt[i].g));
                    check($sformatf("vec%0d core_in_valid", i), int'(core_in_valid), int'(vt[i].civ));
                    check($sformatf("vec%0d core_in_data", i), int'(core_in_data), int'(vt[i].cd));
                    check($sformatf("vec%0d core_op", i), int'(core_op), int'(vt[i].cop));
                    check($sformatf("vec%0d busy", i), int'(busy), int'(vt[i].busy));
                end
            end
            if (grant[0]) req[0] = 1'b0;
        end
        rq.delete();
        wait_res(16, 300);
        check_res(0, 0);
        wait_idle(100);

        // Requester 1 with a gap every other beat: burst still contiguous, order kept.
        gap1 = 1'b1;
        runq.delete(); ciq.delete(); rq.delete();
        run_job(1);
        wait_res(16, 800);
        gap1 = 1'b0;
        check("gapped burst runs", runq.size(), 1);
        check("gapped burst length", (runq.size() > 0) ? runq[0] : 0, 64);
        for (int i = 0; i < 64; i++) begin
            logic [10:0] b;
            b = (ciq.size() > i) ? ciq[i] : 11'h7FF;
            check($sformatf("gapped beat%0d data", i), int'(b[6:0]), int'(pat(1, i)));
            if (i < 16)
                check($sformatf("gapped beat%0d op", i), int'(b[10:7]), (i < 15) ? i : 0);
        end
        check_res(0, 1);
        wait_idle(100);

        // Both requesting continuously: alternate grants, overlapped capture.
        model_lat = 20;
        gq.delete(); gcq.delete(); civq.delete(); rq.delete();
        req = 2'b11;
        k = 0;
        while (gq.size() < 3 && k < 1500) begin
            @(negedge clk);
            k++;
        end
        req = 2'b00;
        check("rr grant count", gq.size(), 3);
        check("rr grant 1", int'(gq.size() > 0 ? gq[0] : 2'b00), 1);
        check("rr grant 2", int'(gq.size() > 1 ? gq[1] : 2'b00), 2);
        check("rr grant 3", int'(gq.size() > 2 ? gq[2] : 2'b00), 1);
        check("overlap grant delay",
              (gcq.size() > 1 && civq.size() > 0) ? gcq[1] - civq[0] : -1, 65);
        wait_res(48, 1500);
        check_res(0, 0);
        check_res(16, 1);
        check_res(32, 0);
        wait_idle(300);
        model_lat = 3;

        // Core never answers: one err pulse 256 cycles into K_WAIT, no results.
        model_en = 1'b0;
        errq.delete(); fallq.delete(); rq.delete();
        run_job(0);
        k = 0;
        while (errq.size() < 1 && k < 800) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        check("timeout err pulses", errq.size(), 1);
        check("timeout err delay",
              (errq.size() > 0 && fallq.size() > 0) ? errq[0] - fallq[0] : -1, 256);
        check("timeout no results", rq.size(), 0);
        check("timeout idle", int'(busy), 0);
        model_en = 1'b1;
        run_job(1);
        wait_res(16, 400);
        check_res(0, 1);
        wait_idle(100);

        // Drain with 3-cycle gaps between result beats.
        model_gap = 3;
        rq.delete();
        run_job(0);
        wait_res(16, 600);
        repeat (10) @(negedge clk);
        check("gapped drain beat count", rq.size(), 16);
        check_res(0, 0);
        check("gapped drain idle", int'(busy), 0);
        check("no spurious err", errq.size(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idc_job_scheduler.md
# idc_job_scheduler

Front-end controller for the IDC image-display datapath. Two requesters each submit jobs of 64 signed 7-bit pixels plus 15 op codes. The block arbitrates between them round-robin and captures the granted job into a local buffer, which tolerates requester gaps. It then streams the job to the IDC core as one contiguous 64-cycle burst, collects the 16 result pixels and returns them tagged with the requester id. Capture of the next job overlaps core processing of the current one.

## Interface
- TIMEOUT, 256, maximum cycles in K_WAIT before the core is declared hung.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  2  per-requester job request, held until granted.
- grant  out  2  one-hot grant; high for the whole capture of the granted job.
- s0_valid / s1_valid  in  1  beat valid from requester 0/1.
- s0_data / s1_data  in  7  signed pixel.
- s0_op / s1_op  in  4  op code, meaningful on beats 0–14 only.
- core_in_valid  out  1  to IDC in_valid.
- core_in_data  out  7  to IDC in_data.
- core_op  out  4  to IDC op.
- core_out_valid  in  1  from IDC out_valid.
- core_out_data  in  7  from IDC out_data.
- res_valid  out  1  result beat valid.
- res_data  out  7  result pixel.
- res_id  out  1  requester that owns the result.
- err  out  1  one-cycle pulse on core timeout.
- busy  out  1  high when either FSM is not idle.

## Operation
- Buffers:
  - pix_buf[0:63] (7b) and op_buf[0:14] (4b).
  - cap_id and core_id, 1b each.
- Capture FSM: C_IDLE → C_FILL → C_FULL → C_IDLE.
  - C_IDLE with any req: pick a winner and set grant, then go to C_FILL.
  - Round-robin: when both requesters request, grant the one not granted last. The pointer resets so requester 0 wins the first tie.
  - C_FILL: a beat is accepted on each cycle with grant[i] & si_valid.
  - Beat k writes pix_buf[k]; beats k<15 also write op_buf[k]. The 6-bit capture count increments per beat.
  - On acceptance of beat 63, go to C_FULL and clear grant.
  - C_FULL → C_IDLE when the core FSM finishes its burst (buffer freed).
- Core FSM: K_IDLE → K_BURST → K_WAIT → K_DRAIN → K_IDLE.
  - K_IDLE with C_FULL: latch core_id = cap_id, go to K_BURST.
  - K_BURST: 64 consecutive cycles with core_in_valid=1 and core_in_data=pix_buf[i]. core_op=op_buf[i] for i<15, else 0. No gaps allowed.
  - After i=63, go to K_WAIT and free the capture buffer.
  - K_WAIT: timer counts up. On core_out_valid, go to K_DRAIN.
  - Timer reaching TIMEOUT with no core_out_valid: pulse err, go to K_IDLE. No results are returned for that job.
  - K_DRAIN: each core_out_valid beat is forwarded, with res_id=core_id. Gaps in core_out_valid are waited out, with no timeout.
  - After the 16th beat, go to K_IDLE.
- All core_* and res_* outputs are registered. When no beat is valid, data outputs are driven 0.
- Ignored inputs:
  - req while capture is not in C_IDLE.
  - si_valid without grant[i].
  - core_out_valid in K_IDLE or K_BURST.

## Timing
- Reset value of every output is 0: grant=00, core_in_valid, core_in_data, core_op, res_valid, res_data, res_id, err, busy.
- Reset state:
  - both FSMs idle, counters 0, RR pointer selects requester 0.
  - buffers are not required to clear.
  - Reset mid-burst or mid-drain aborts immediately; outputs go to 0 asynchronously.
- req sampled high at cycle t: grant is high from t+1. A beat is acceptable at t+1 if si_valid is high then.
- Beat 63 accepted at cycle u: grant is low at u+1 and capture is C_FULL at u+1.
- If the core is idle, first core_in_valid is at u+2 and the last at u+65.
- Capture returns to C_IDLE at u+66. A pending req gets its grant at u+67.
- core_out_valid at cycle v: res_valid at v+1 with the same data.
- Simultaneous events:
  - C_FULL with the core busy: the job waits in the buffer, grant stays low.
  - Both req rising in the same cycle: the RR pointer decides the winner.

## Test plan
- Reset then idle: all outputs 0 and busy=0. Assert rst mid-K_BURST → core_in_valid=0 in the same cycle; after release, req0 → grant=01.
- Single job, requester 0, contiguous beats at t=1..64 (pixels 0..63, ops 0..14 = 5), then a model core returning 16 beats → core_in_valid at 66..129 with data 0..63. core_op=5 on the first 15 burst beats, 0 after. res_valid×16 with res_id=0.
- Requester 1 with a valid gap every other cycle → the burst is still 64 contiguous cycles and the pixel order is preserved.
- req=11 held continuously → grants in order 01, 10, 01. Job 2's capture overlaps job 1's K_WAIT. res_id sequence 0, 1, 0.
- Core never answers, TIMEOUT=256 → err pulses exactly once 256 cycles after entering K_WAIT, no res_valid, and the next job proceeds normally.
- core_out_valid with 3-cycle gaps during drain → exactly 16 res beats, none dropped, then K_IDLE.
